// File: rtl/pcis_write_packet_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : pcis_write_packet_pkg                                         |
// | Brief   : Shared AOS fabric types and AXI constants used by the PCIS    |
// |           write-side packet bridge (app field width, AOSPacket layout,  |
// |           AXI response codes, legal beat size).                         |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package pcis_write_packet_pkg;

  // Number of address bits used to pick the destination app
  localparam int AMI_APP_BITS = 2;

  // AXI write response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Only full 64-byte beats are supported
  localparam logic [2:0] PCIS_BEAT_SIZE  = 3'b110;

  // Outbound fabric beat; the bridge drives only valid and data
  typedef struct packed {
    logic         valid;
    logic [511:0] data;
    logic [63:0]  addr;
    logic [15:0]  tag;
    logic         last;
  } AOSPacket;

  // Destination app encoded just above the 8 KiB per-app window
  function automatic logic [AMI_APP_BITS-1:0] app_of(input logic [63:0] addr);
    return addr[13 +: AMI_APP_BITS];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcis_write_packet.sv
// ---------------------------------------------------------------------------
// | Module  : pcis_write_packet                                             |
// | Brief   : Converts PCIS AXI4 write bursts into AOSPacket beats for the  |
// |           app router and returns one B response per burst. Data path is |
// |           combinational; control state is registered.                   |
// |           Optional checking enabled by defining PCIS_WRITE_CHECK_EN.    |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module pcis_write_packet
  import pcis_write_packet_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              sh_cl_dma_pcis_awid,
  input  logic [63:0]             sh_cl_dma_pcis_awaddr,
  input  logic [7:0]              sh_cl_dma_pcis_awlen,
  input  logic [2:0]              sh_cl_dma_pcis_awsize,
  input  logic                    sh_cl_dma_pcis_awvalid,
  output logic                    cl_sh_dma_pcis_awready,
  input  logic [511:0]            sh_cl_dma_pcis_wdata,
  input  logic [63:0]             sh_cl_dma_pcis_wstrb,
  input  logic                    sh_cl_dma_pcis_wlast,
  input  logic                    sh_cl_dma_pcis_wvalid,
  output logic                    cl_sh_dma_pcis_wready,
  output logic [5:0]              cl_sh_dma_pcis_bid,
  output logic [1:0]              cl_sh_dma_pcis_bresp,
  output logic                    cl_sh_dma_pcis_bvalid,
  input  logic                    sh_cl_dma_pcis_bready,
  output AOSPacket                packet_out,
  output logic [AMI_APP_BITS-1:0] packet_out_app,
  input  logic                    packet_out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [5:0]              r_id;
  logic [7:0]              r_len;
  logic [AMI_APP_BITS-1:0] r_app;
  logic                    r_err;
  logic                    r_drop;   // burst address illegal: swallow beats

  logic w_aw_err;
  logic w_last_err;
  logic w_in_recv;
  logic w_wready;
  logic w_beat;

`ifdef PCIS_WRITE_CHECK_EN
  assign w_aw_err   = (sh_cl_dma_pcis_awaddr[12:0] != 13'd0) ||
                      (sh_cl_dma_pcis_awsize != PCIS_BEAT_SIZE);
  assign w_last_err = sh_cl_dma_pcis_wlast != (r_len == 8'd0);
`else
  assign w_aw_err   = 1'b0;
  assign w_last_err = 1'b0;
`endif

  // Strobes are ignored and, without checking, so are size/offset/wlast
  logic w_unused_ok;
  assign w_unused_ok = ^{sh_cl_dma_pcis_wstrb, sh_cl_dma_pcis_awaddr[63:13+AMI_APP_BITS],
                         sh_cl_dma_pcis_awaddr[12:0], sh_cl_dma_pcis_awsize,
                         sh_cl_dma_pcis_wlast};

  // Beats are accepted only in RECV; a dropped burst drains regardless of downstream
  assign w_in_recv = !rst && (r_state == S_RECV);
  assign w_wready  = w_in_recv && (r_drop || packet_out_ready);
  assign w_beat    = w_wready && sh_cl_dma_pcis_wvalid;

  assign cl_sh_dma_pcis_awready = !rst && (r_state == S_IDLE);
  assign cl_sh_dma_pcis_wready  = w_wready;
  assign cl_sh_dma_pcis_bvalid  = !rst && (r_state == S_RESP);
  assign cl_sh_dma_pcis_bid     = rst ? 6'd0 : r_id;
  assign cl_sh_dma_pcis_bresp   = (!rst && r_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign packet_out_app         = rst ? '0 : r_app;

  // Pass-through of the current W beat onto the fabric
  always_comb begin
    packet_out       = '0;
    packet_out.valid = w_in_recv && !r_drop && sh_cl_dma_pcis_wvalid;
    packet_out.data  = w_in_recv ? sh_cl_dma_pcis_wdata : 512'd0;
  end

  // Burst control: latch AW, count beats down to zero, then hold B until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= 6'd0;
      r_len   <= 8'd0;
      r_app   <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sh_cl_dma_pcis_awvalid) begin
            r_id    <= sh_cl_dma_pcis_awid;
            r_len   <= sh_cl_dma_pcis_awlen;
            r_app   <= app_of(sh_cl_dma_pcis_awaddr);
            r_err   <= w_aw_err;
            r_drop  <= w_aw_err;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_beat) begin
            r_len <= r_len - 8'd1;
            if (w_last_err) begin
              r_err <= 1'b1;
            end
            if (r_len == 8'd0) begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (sh_cl_dma_pcis_bready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcis_write_packet.sv
// ---------------------------------------------------------------------------
// | Module  : tb_pcis_write_packet                                          |
// | Brief   : Directed self-checking bench for pcis_write_packet. Expected  |
// |           responses adapt to PCIS_WRITE_CHECK_EN when it is defined.    |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pcis_write_packet;
  import pcis_write_packet_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [5:0]              awid;
  logic [63:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;
  logic [511:0]            wdata;
  logic [63:0]             wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [5:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  AOSPacket                packet_out;
  logic [AMI_APP_BITS-1:0] packet_out_app;
  logic                    por;

  int           n_chk = 0;
  int           n_fail = 0;
  int           pkt_cnt = 0;
  int           b_cnt = 0;
  int           aw_viol = 0;
  bit           busy = 1'b0;
  logic [511:0] exp_q[$];
  logic [1:0]   exp_app = '0;

  always #5 clk = ~clk;

  pcis_write_packet dut (
    .clk                    (clk),
    .rst                    (rst),
    .sh_cl_dma_pcis_awid    (awid),
    .sh_cl_dma_pcis_awaddr  (awaddr),
    .sh_cl_dma_pcis_awlen   (awlen),
    .sh_cl_dma_pcis_awsize  (awsize),
    .sh_cl_dma_pcis_awvalid (awvalid),
    .cl_sh_dma_pcis_awready (awready),
    .sh_cl_dma_pcis_wdata   (wdata),
    .sh_cl_dma_pcis_wstrb   (wstrb),
    .sh_cl_dma_pcis_wlast   (wlast),
    .sh_cl_dma_pcis_wvalid  (wvalid),
    .cl_sh_dma_pcis_wready  (wready),
    .cl_sh_dma_pcis_bid     (bid),
    .cl_sh_dma_pcis_bresp   (bresp),
    .cl_sh_dma_pcis_bvalid  (bvalid),
    .sh_cl_dma_pcis_bready  (bready),
    .packet_out             (packet_out),
    .packet_out_app         (packet_out_app),
    .packet_out_ready       (por)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] beat_data(input logic [31:0] seed, input int i);
    logic [31:0] w;
    w = seed + 32'(i);
    return {16{w}};
  endfunction

  // Scoreboard: every forwarded packet must match the next expected beat
  always @(posedge clk) begin
    if (!rst && packet_out.valid && por) begin
      pkt_cnt++;
      if (exp_q.size() == 0) begin
        check("pkt_unexpected", packet_out.data, 512'd0);
        check("pkt_unexpected_flag", 1, 0);
      end else begin
        check("pkt_data", packet_out.data, exp_q.pop_front());
        check("pkt_app", packet_out_app, exp_app);
        check("pkt_sideband", {packet_out.addr, packet_out.tag, packet_out.last}, 0);
      end
    end
    if (!rst && bvalid && bready) b_cnt++;
    if (busy && awready) aw_viol++;
  end

  task automatic send_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
    bit got;
    got = 1'b0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = 3'b110; awvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (awready) begin
        got = 1'b1;
        break;
      end
    end
    check("aw_accept", got, 1);
    @(negedge clk);
    awvalid = 1'b0;
    busy = 1'b1;
  endtask

  // Sends n beats starting at the current negedge; returns at the negedge after the last accept
  task automatic send_w(input int n, input logic [31:0] seed, input bit toggle, input bit fwd);
    bit acc;
    for (int i = 0; i < n; i++) begin
      wdata = beat_data(seed, i);
      wlast = (i == n - 1);
      wvalid = 1'b1;
      if (fwd) exp_q.push_back(beat_data(seed, i));
      acc = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (toggle) por = ~por;
        @(posedge clk);
        if (wready) acc = 1'b1;
        @(negedge clk);
        if (acc) break;
      end
      check("w_accept", acc, 1);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    por = 1'b1;
  endtask

  // Expects B already valid at the current negedge; holds bready low for hold cycles
  task automatic take_b(input logic [5:0] id, input logic [1:0] resp, input int hold);
    int low;
    low = 0;
    check("bvalid_next_cycle", bvalid, 1);
    check("bid", bid, id);
    check("bresp", bresp, resp);
    if (hold > 0) begin
      awvalid = 1'b1;
      awaddr = 64'h6000;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!bvalid) low++;
      end
      check("bvalid_held", low, 0);
      check("awready_during_resp", awready, 0);
      awvalid = 1'b0;
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    busy = 1'b0;
    check("bvalid_clear", bvalid, 0);
    check("app_hold_idle", packet_out_app, exp_app);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, b0;
    logic [1:0] err_resp;
    bit err_fwd;
    rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awsize = 3'b110; awvalid = 1'b0;
    wdata = '0; wstrb = '1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; por = 1'b1;

    // Reset: all outputs low, even with requests pending
    repeat (3) @(negedge clk);
    awvalid = 1'b1;
    #1;
    check("rst_awready", awready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_pkt_valid", packet_out.valid, 0);
    check("rst_app", packet_out_app, 0);
    awvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("awready_after_rst", awready, 1);

    // Single beat to app 1
    exp_app = 2'd1;
    p0 = pkt_cnt;
    send_aw(6'h15, 64'h2000, 8'd0);
    send_w(1, 32'hA5A5A5A5, 1'b0, 1'b1);
    check("single_pkts", pkt_cnt - p0, 1);
    take_b(6'h15, AXI_RESP_OKAY, 0);

    // 4 beats with downstream ready toggling
    exp_app = 2'd2;
    p0 = pkt_cnt;
    send_aw(6'h2A, 64'h4000, 8'd3);
    send_w(4, 32'h1000_0000, 1'b1, 1'b1);
    check("toggle_pkts", pkt_cnt - p0, 4);
    check("toggle_q_empty", exp_q.size(), 0);
    take_b(6'h2A, AXI_RESP_OKAY, 0);

    // 256-beat burst, then B held off for 5 cycles with a new AW waiting
    exp_app = 2'd3;
    p0 = pkt_cnt;
    aw_viol = 0;
    send_aw(6'h01, 64'h6000, 8'd255);
    send_w(256, 32'h0000_0100, 1'b0, 1'b1);
    check("long_pkts", pkt_cnt - p0, 256);
    take_b(6'h01, AXI_RESP_OKAY, 5);
    check("awready_low_busy", aw_viol, 0);

    // Reset after 2 of 4 beats: no B, then a normal burst
    exp_app = 2'd0;
    b0 = b_cnt;
    send_aw(6'h07, 64'h0000, 8'd3);
    send_w(2, 32'hDEAD_0000, 1'b0, 1'b1);
    rst = 1'b1;
    busy = 1'b0;
    @(negedge clk);
    check("midrst_bvalid", bvalid, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_b", b_cnt - b0, 0);
    check("midrst_idle", awready, 1);
    exp_app = 2'd1;
    p0 = pkt_cnt;
    send_aw(6'h08, 64'h2000, 8'd1);
    send_w(2, 32'hBEEF_0000, 1'b0, 1'b1);
    check("post_rst_pkts", pkt_cnt - p0, 2);
    take_b(6'h08, AXI_RESP_OKAY, 0);

    // Misaligned start address: drained with SLVERR when checking, forwarded otherwise
`ifdef PCIS_WRITE_CHECK_EN
    err_fwd = 1'b0;
    err_resp = AXI_RESP_SLVERR;
`else
    err_fwd = 1'b1;
    err_resp = AXI_RESP_OKAY;
`endif
    exp_app = 2'd1;
    p0 = pkt_cnt;
    por = 1'b0;
    send_aw(6'h33, 64'h2040, 8'd1);
    por = 1'b1;
    send_w(2, 32'h5555_0000, 1'b0, err_fwd);
    check("misalign_pkts", pkt_cnt - p0, err_fwd ? 2 : 0);
    take_b(6'h33, err_resp, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcis_write_packet.md
# pcis_write_packet

Translates host writes on the PCIS (DMA) AXI4 write channels into outbound AOSPacket beats for the AOS app fabric, and returns one write response per burst. It is the host-to-app counterpart of the PCIS read-side packet bridge and sits between the shell's `sh_cl_dma_pcis_*` write channels and the AOS app router. Data path is pass-through (not registered); control state is registered.

## Interface
Parameters:
- none; widths come from `AMITypes`/`AOSF1Types` (`AMI_APP_BITS`, `AOSPacket`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `sh_cl_dma_pcis_awid`  in  6  write address ID
- `sh_cl_dma_pcis_awaddr`  in  64  burst start address; `[13 +: AMI_APP_BITS]` selects app
- `sh_cl_dma_pcis_awlen`  in  8  beats minus one
- `sh_cl_dma_pcis_awsize`  in  3  beat size (legal: `3'b110`, 64 B)
- `sh_cl_dma_pcis_awvalid`  in  1  address valid
- `cl_sh_dma_pcis_awready`  out  1  address ready
- `sh_cl_dma_pcis_wdata`  in  512  write data
- `sh_cl_dma_pcis_wstrb`  in  64  byte strobes (ignored; full beats only)
- `sh_cl_dma_pcis_wlast`  in  1  last beat marker
- `sh_cl_dma_pcis_wvalid`  in  1  data valid
- `cl_sh_dma_pcis_wready`  out  1  data ready
- `cl_sh_dma_pcis_bid`  out  6  response ID (= latched awid)
- `cl_sh_dma_pcis_bresp`  out  2  response code
- `cl_sh_dma_pcis_bvalid`  out  1  response valid
- `sh_cl_dma_pcis_bready`  in  1  response ready
- `packet_out`  out  AOSPacket  `.valid`, `.data`; all other fields driven 0
- `packet_out_app`  out  AMI_APP_BITS  destination app for routing
- `packet_out_ready`  in  1  downstream accepts packet

## Operation
- States: IDLE, RECV, RESP.
- IDLE: `awready`=1. On `awvalid`: latch `id`←awid, `len`←awlen, `app`←awaddr app field, `err`←0; go RECV.
- RECV: `packet_out.valid`=`wvalid`, `packet_out.data`=`wdata`, `wready`=`packet_out_ready`. Beat accepted when `wvalid && packet_out_ready`: `len`←`len-1`; if `len`==0 go RESP.
- Beat count is authoritative for burst end; `wlast` does not end a burst.
- RESP: `bvalid`=1, `bid`=`id`, `bresp`=OKAY (2'b00) unless `err`. On `bready` go IDLE.
- `packet_out_app`=latched `app` in all states.
- `len` is 8-bit unsigned; awlen=255 → 256 beats; no wrap issue since burst ends at 0.

## Timing
- Reset (rst high): state IDLE, `id`/`len`/`app`/`err`=0; all outputs 0 while rst high, including `awready`. `awready`=1 from first cycle after rst deasserts.
- AW accept → first W beat may be accepted the next cycle (1-cycle minimum).
- W beat → `packet_out` same cycle (0 latency, combinational).
- Last W beat accepted cycle N → `bvalid` at N+1; next AW accepted earliest cycle after `bvalid && bready` (one burst in flight; `awready`=0 in RECV/RESP).
- `wvalid` with `packet_out_ready`=0: stall, no count change; `wvalid` dropping mid-burst: no effect.
- `awvalid` in RECV/RESP: ignored (held by master).
- rst mid-burst: immediate return to IDLE; partial burst abandoned, no B response.

## Configuration
- `PCIS_WRITE_CHECK_EN` defined: at AW accept, set `err` if `awaddr[12:0]`≠0 or `awsize`≠`3'b110`; when `err` set in RECV, beats are drained (`wready`=1, `packet_out.valid`=0). Also set `err` if `wlast` mismatches `len`==0 on an accepted beat (beats still forwarded if address was legal). `err` → `bresp`=SLVERR (2'b10).
- Undefined: no checks, `err` constant 0, `bresp` always OKAY.

## Structure
- `AXI_RESP_OKAY`, `AXI_RESP_SLVERR` constants belong in `AOSF1Types`; `state_t` local to module.
- Single module, no sub-module.

## Test plan
- Single beat: awaddr=0x2000 (app 1), awlen=0, one W beat 0xA5… → one packet, app=1, `bvalid` next cycle, bresp=0, bid=awid.
- 4-beat burst with `packet_out_ready` toggling 1/0 → exactly 4 packets in order, data unchanged, one B response.
- awlen=255 → 256 packets, then B; `awready` low throughout.
- `bready` held low 5 cycles → `bvalid` held, new `awvalid` not accepted until handshake.
- rst asserted after 2 of 4 beats → no B, IDLE; next burst behaves normally.
- With `PCIS_WRITE_CHECK_EN`: awaddr=0x2040 → beats drained, no packets, bresp=2'b10; without macro same stimulus → packets forwarded, bresp=0.
